jk_bank_controller: RTL and testbench
=====================================

# jk_bank_controller

Command-driven sequencer for a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake and translates it into per-bit J/K drive: hold, masked set, masked clear, masked toggle, or a multi-cycle up/down count of N steps. It sits between a lab-level stimulus source (testbench or switch/FSM front end) and the JK storage cells, so the cells are only ever driven through legal, sequenced J/K patterns.

## Interface
- WIDTH, 4, number of JK cells in the bank
- CNT_W, 8, width of the step-count field
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command (IDLE only)
- cmd_op  input  3  0 HOLD, 1 SET, 2 CLEAR, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN, 6–7 reserved
- cmd_mask  input  WIDTH  bit-select for SET/CLEAR/TOGGLE; ignored by counts
- cmd_steps  input  CNT_W  number of count steps; ignored by non-count ops
- q  output  WIDTH  bank state
- qbar  output  WIDTH  complement of q
- busy  output  1  command in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse, command complete

## Operation
- States: IDLE, EXEC, COUNT.
- IDLE: cmd_ready=1; all J=K=0. On cmd_valid&&cmd_ready, register op/mask/steps:
  - ops 0–3 go to EXEC
  - ops 4–5 with steps≠0 go to COUNT, remaining ← steps
  - ops 4–5 with steps=0 go to EXEC as HOLD
  - reserved ops 6–7 execute as HOLD
- EXEC (exactly one cycle): per bit i with mask[i]=1:
  - SET: J=1, K=0
  - CLEAR: J=0, K=1
  - TOGGLE: J=K=1
  - HOLD: J=K=0 for all bits
  - Unmasked bits: J=K=0.
  - Next state IDLE; done pulses.
- COUNT: each cycle bit i gets J=K=1 iff all lower bits are 1 (UP) or all 0 (DOWN); bit 0 always toggles. remaining decrements each cycle; on the cycle remaining=1, next state IDLE and done pulses.
- Wrap-around is modular: UP from all-ones → 0; DOWN from 0 → all-ones.
- cmd_valid while busy: ignored, command not consumed; the source must hold it until cmd_ready.
- J/K combinations are a pure function of registered state; never a direct function of cmd_* inputs.

## Timing
- Reset (synchronous, checked at rising edge): q=0, qbar=all-ones, state IDLE, busy=0, done=0, remaining=0. cmd_ready=0 while reset is asserted; 1 in the first cycle after deassertion.
- Reset mid-operation: aborts immediately. No done pulse. The bank clears to 0 at that same edge.
- Handshake at edge E0 → EXEC during cycle after E0 → q updated at E1. done=1 and cmd_ready=1 in the cycle after E1. Minimum command spacing: 2 cycles.
- COUNT with steps=N accepted at E0: q updates at E1…EN (one step per edge). done high for one cycle after EN, coincident with cmd_ready returning to 1.
- done is registered and never high for two consecutive cycles.
- busy = (state≠IDLE), registered. qbar = ~q at all times.

## Structure
- Shared package jk_ctrl_pkg holds:
  - op-code constants: OP_HOLD, OP_SET, OP_CLEAR, OP_TOGGLE, OP_UP, OP_DOWN
  - state encodings: S_IDLE, S_EXEC, S_COUNT
- Sub-module jk_cell: one JK flip-flop with ports clk, reset, j, k, q, qbar.
  - Synchronous active-high reset to q=0.
  - 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.
- Top level holds the FSM, the command registers, the remaining counter, and J/K decode logic.

## Test plan
- Reset behaviour: assert reset 2 cycles → q=0000, qbar=1111, busy=0, done=0, cmd_ready=0 during reset and 1 after.
- SET then CLEAR: SET mask=0101 from 0000 → q=0101 one edge after accept, done one pulse. Then CLEAR mask=0001 → q=0100.
- TOGGLE: TOGGLE mask=1111 from 0101 → q=1010. Then HOLD mask=1111 → q stays 1010, done still pulses.
- COUNT_UP wrap: from q=1110, UP steps=3 → q=1111, 0000, 0001 on three successive edges; busy=1 throughout; done pulses once after the third.
- COUNT_DOWN wrap and zero steps: from 0000, DOWN steps=2 → q=1111, 1110. Then UP steps=0 → q unchanged, done after 1 cycle.
- Backpressure and abort:
  - Hold cmd_valid with SET mask=1111 during an UP steps=5 → not accepted until cmd_ready; applied after the count completes.
  - Assert reset at step 3 of a second count → q=0000 at that edge, no done, IDLE afterwards.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared op-codes, state encoding and field widths for the JK bank controller.
package jk_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'd0;
  localparam logic [OP_W-1:0] OP_SET    = 3'd1;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'd2;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'd3;
  localparam logic [OP_W-1:0] OP_UP     = 3'd4;
  localparam logic [OP_W-1:0] OP_DOWN   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_COUNT = 2'd2
  } state_e;

  // Count ops carry a step count; everything else is a single-cycle EXEC.
  function automatic logic is_count_op(input logic [OP_W-1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_bank_controller_if.sv
// Command handshake and bank status bundle between a stimulus source and the controller.
interface jk_bank_controller_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_steps;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_steps,
    input  cmd_ready, q, qbar, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_steps,
    output cmd_ready, q, qbar, busy, done
  );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle; sync active-high reset.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);
  logic q_q;
  logic q_d;
  logic qbar_q;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // qbar gets its own flop loaded with the complement so it tracks q edge for edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= 1'b0;
      qbar_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
endmodule

// File: rtl/jk_bank_controller.sv
// Command sequencer for a bank of JK cells: masked set/clear/toggle/hold and N-step up/down counts.
module jk_bank_controller
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_bank_controller_if.slave  bus
);
  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic [WIDTH-1:0] j, k, tgl;
  logic [WIDTH-1:0] q_w, qbar_w;

  assign accept = bus.cmd_valid & ready_q;

  // State register and command/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_HOLD;
      mask_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_count_op(bus.cmd_op) && (bus.cmd_steps != '0)) state_d = S_COUNT;
          else                                                   state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_IDLE;
      S_COUNT: if (remaining_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command capture, status outputs and J/K decode from registered state only.
  always_comb begin
    op_d        = op_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    j           = '0;
    k           = '0;
    tgl         = '0;

    // Count carry chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
    tgl[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      tgl[i] = tgl[i-1] & ((op_q == OP_UP) ? q_w[i-1] : ~q_w[i-1]);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mask_d      = bus.cmd_mask;
          remaining_d = bus.cmd_steps;
          // Zero-step counts and reserved codes collapse to HOLD.
          if (bus.cmd_op > OP_DOWN || (is_count_op(bus.cmd_op) && bus.cmd_steps == '0))
            op_d = OP_HOLD;
          else
            op_d = bus.cmd_op;
        end
      end
      S_EXEC: begin
        done_d      = 1'b1;
        remaining_d = '0;
        unique case (op_q)
          OP_SET:    j = mask_q;
          OP_CLEAR:  k = mask_q;
          OP_TOGGLE: begin
            j = mask_q;
            k = mask_q;
          end
          default: ;
        endcase
      end
      S_COUNT: begin
        j           = tgl;
        k           = tgl;
        remaining_d = remaining_q - CNT_W'(1);
        done_d      = (remaining_q == CNT_W'(1));
      end
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (j[g]),
      .k    (k[g]),
      .q    (q_w[g]),
      .qbar (qbar_w[g])
    );
  end

  assign bus.q         = q_w;
  assign bus.qbar      = qbar_w;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = ready_q;
endmodule

// File: tb/tb_jk_bank_controller.sv
// Directed plus randomized bench for jk_bank_controller against an arithmetic model of the bank.
module tb_jk_bank_controller;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MODV  = 1 << WIDTH;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   model_q;

  jk_bank_controller_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  jk_bank_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string tag);
    check({tag, "_q"}, int'(bus.q), model_q);
    check({tag, "_qbar"}, int'(bus.qbar), (~model_q) & (MODV - 1));
  endtask

  // Single-edge effect of a non-count command on the bank.
  function automatic int apply_op(input int qv, input int op, input int mask);
    case (op)
      1:       return qv | mask;
      2:       return qv & ~mask & (MODV - 1);
      3:       return (qv ^ mask) & (MODV - 1);
      default: return qv;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check({tag, "_ready_wait"}, int'(bus.cmd_ready), 1);
  endtask

  // Issue one command and follow it edge by edge to completion.
  task automatic do_cmd(input string tag, input int op, input int mask, input int steps);
    bit is_cnt;
    int n;
    wait_ready(tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_mask  = WIDTH'(mask);
    bus.cmd_steps = CNT_W'(steps);
    tick();
    bus.cmd_valid = 1'b0;
    is_cnt = (op == 4 || op == 5) && steps != 0;
    n      = is_cnt ? steps : 1;
    for (int s = 0; s < n; s++) begin
      check({tag, "_busy"}, int'(bus.busy), 1);
      check({tag, "_done_early"}, int'(bus.done), 0);
      check({tag, "_ready_busy"}, int'(bus.cmd_ready), 0);
      tick();
      if (is_cnt) model_q = (op == 4) ? (model_q + 1) % MODV : (model_q + MODV - 1) % MODV;
      else        model_q = apply_op(model_q, op, mask);
      check_bank(tag);
    end
    check({tag, "_done"}, int'(bus.done), 1);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
    check({tag, "_ready_end"}, int'(bus.cmd_ready), 1);
    tick();
    check({tag, "_done_once"}, int'(bus.done), 0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    model_q       = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_mask  = '0;
    bus.cmd_steps = '0;
    reset         = 1'b1;

    tick();
    tick();
    check_bank("rst");
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ready", int'(bus.cmd_ready), 0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", int'(bus.cmd_ready), 1);
    check_bank("rst_after");

    do_cmd("set0101", 1, 4'b0101, 0);
    do_cmd("clr0001", 2, 4'b0001, 0);
    do_cmd("tgl1111", 3, 4'b1111, 0);
    do_cmd("hold", 0, 4'b1111, 0);
    do_cmd("clr_all", 2, 4'b1111, 0);
    do_cmd("set1110", 1, 4'b1110, 0);
    do_cmd("up_wrap", 4, 0, 3);
    check("up_wrap_val", model_q, 1);
    do_cmd("clr_all2", 2, 4'b1111, 0);
    do_cmd("down_wrap", 5, 0, 2);
    check("down_wrap_val", model_q, 4'b1110);
    do_cmd("up_zero", 4, 4'b1111, 0);
    do_cmd("rsvd6", 6, 4'b1111, 3);
    do_cmd("rsvd7", 7, 4'b0101, 0);

    // Backpressure: a SET held on the bus during a count must wait for cmd_ready.
    wait_ready("bp");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_mask  = '0;
    bus.cmd_steps = CNT_W'(5);
    tick();
    bus.cmd_op    = 3'd1;
    bus.cmd_mask  = 4'b1111;
    bus.cmd_steps = '0;
    for (int s = 0; s < 5; s++) begin
      check("bp_ready_low", int'(bus.cmd_ready), 0);
      tick();
      model_q = (model_q + 1) % MODV;
      check_bank("bp_count");
    end
    check("bp_done", int'(bus.done), 1);
    check("bp_ready", int'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_exec_busy", int'(bus.busy), 1);
    check_bank("bp_exec_hold");
    tick();
    model_q = MODV - 1;
    check_bank("bp_set");
    check("bp_set_done", int'(bus.done), 1);
    tick();

    // Abort: reset at the third step of a count clears the bank with no done pulse.
    wait_ready("abort");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_steps = CNT_W'(6);
    tick();
    bus.cmd_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      model_q = (model_q + 1) % MODV;
      check_bank("abort_count");
    end
    reset = 1'b1;
    tick();
    model_q = 0;
    check_bank("abort_rst");
    check("abort_done", int'(bus.done), 0);
    check("abort_busy", int'(bus.busy), 0);
    reset = 1'b0;
    tick();
    check("abort_idle_ready", int'(bus.cmd_ready), 1);
    check("abort_idle_done", int'(bus.done), 0);
    check_bank("abort_idle");

    for (int r = 0; r < 25; r++) begin
      do_cmd("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, MODV - 1)),
             int'($urandom_range(0, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
